// File: rtl/mux16_serializer_if.sv
// Word-in / bit-out handshake bundle for the 16:1 mux serializer.
interface mux16_serializer_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ser_out;
    logic        ser_valid;
    logic        ser_last;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, ser_last
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, ser_last
    );
endinterface

// File: rtl/mux16_serializer.sv
// Latches a 16-bit word onto an external 16:1 mux and walks its select,
// emitting the mux output as a framed serial stream (valid/last strobes).
module mux16_serializer #(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    mux16_serializer_if.slave   bus,
    input  logic                flush,
    output logic [15:0]         mux_in,
    output logic [3:0]          mux_sel,
    input  logic                mux_out,
    output logic                busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0] SEL_START = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [7:0] DIV_LAST  = 8'(BIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        ser_out_q, ser_out_d;
    logic        ser_valid_q, ser_valid_d;
    logic        ser_last_q, ser_last_d;

    function automatic logic [3:0] step_sel(input logic [3:0] s);
        return MSB_FIRST ? s - 4'd1 : s + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            sel_q       <= SEL_START;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            sel_q       <= sel_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        sel_d       = sel_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // flush wins over a simultaneous handshake
                if (!flush && bus.in_valid) begin
                    word_d    = bus.in_data;
                    sel_d     = SEL_START;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d   = IDLE;
                    sel_d     = SEL_START;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    ser_out_d   = mux_out;
                    ser_valid_d = 1'b1;
                    ser_last_d  = (bit_cnt_q == 4'd15);
                    div_cnt_d   = '0;
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    sel_d       = step_sel(sel_q);
                    if (bit_cnt_q == 4'd15) begin
                        state_d = IDLE;
                        sel_d   = SEL_START;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mux_in        = word_q;
    assign mux_sel       = sel_q;
    assign busy          = (state_q == SHIFT);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;

endmodule
